addr_sequencer: RTL
===================

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the memory address width.
REQ-002 Parameter BITS_PER_WORD, default 8, range 2..256, SHALL set the sclk rising edges per word.
REQ-003 Parameter CNT_WIDTH, default 8, SHALL satisfy 2**CNT_WIDTH >= BITS_PER_WORD.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sclkPosEdge  input  1  one-clk pulse marking a serial-clock rising edge.
REQ-007 pcEn  input  1  count enable; 0 pauses all counting.
REQ-008 load  input  1  one-clk request to capture a new address range.
REQ-009 loadStart  input  ADDR_WIDTH  first address of the range.
REQ-010 loadEnd  input  ADDR_WIDTH  last address of the range.
REQ-011 oneShot  input  1  mode: 0 = wrap to start forever, 1 = stop after end.
REQ-012 memAddr  output  ADDR_WIDTH  current memory address (registered).
REQ-013 bitCount  output  CNT_WIDTH  sclk edges counted within the current word (registered).
REQ-014 wordStrobe  output  1  one-clk pulse on each word advance (registered).
REQ-015 busy  output  1  high in RUN state.
REQ-016 done  output  1  high in DONE state.

Function
REQ-017 States SHALL be IDLE, RUN and DONE.
REQ-018 Internal startAddr/endAddr registers SHALL hold the active range; the oneShot input SHALL be sampled live.
REQ-019 load=1 in any state SHALL set startAddr<=loadStart, endAddr<=loadEnd, memAddr<=loadStart, bitCount<=0, state<=IDLE.
REQ-020 load SHALL win over pcEn/sclkPosEdge in the same cycle; no tick or strobe occurs that cycle.
REQ-021 IDLE with pcEn=1 and load=0 SHALL move to RUN on the next edge; sclkPosEdge in that cycle SHALL be ignored.
REQ-022 RUN with pcEn=0 SHALL hold memAddr, bitCount and state.
REQ-023 A tick SHALL be RUN and pcEn=1 and sclkPosEdge=1 and load=0.
REQ-024 A tick with bitCount < BITS_PER_WORD-1 SHALL increment bitCount only.
REQ-025 A tick with bitCount == BITS_PER_WORD-1 SHALL clear bitCount and assert wordStrobe for exactly the next clk cycle.
REQ-026 At that word boundary with memAddr != endAddr, memAddr SHALL increment modulo 2**ADDR_WIDTH.
REQ-027 At that word boundary with memAddr == endAddr and oneShot=0, memAddr SHALL load startAddr and stay in RUN.
REQ-028 At that word boundary with memAddr == endAddr and oneShot=1, memAddr SHALL hold and state SHALL go to DONE.
REQ-029 startAddr > endAddr SHALL be legal; addresses increment through 2**ADDR_WIDTH-1 to 0 until endAddr.
REQ-030 startAddr == endAddr SHALL be legal; that single address repeats (wrap) or finishes after one word (one-shot).
REQ-031 DONE SHALL ignore pcEn and sclkPosEdge and be left only by load or reset.
REQ-032 wordStrobe SHALL be 0 in every cycle not following a word boundary.

Reset
REQ-033 reset=1 SHALL override all inputs, including load.
REQ-034 Reset values: state=IDLE, memAddr=0, bitCount=0, wordStrobe=0, busy=0, done=0, startAddr=0, endAddr=2**ADDR_WIDTH-1.
REQ-035 reset asserted mid-word or mid-range SHALL discard progress; no wordStrobe is issued.

Verification
REQ-036 Defaults, reset, pcEn=1, 16 ticks -> busy=1, memAddr 0->1->2, wordStrobe pulses twice, bitCount back at 0.
REQ-037 load 0x0010..0x0012, oneShot=0, 32 ticks -> addresses 0x10, 0x11, 0x12, 0x10, then 0x11.
REQ-038 load 0x0010..0x0011, oneShot=1, 16 ticks -> done=1, busy=0, memAddr=0x11; further ticks do not change anything.
REQ-039 load 0xFFFE..0x0001, oneShot=0, 32 ticks -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, then 0xFFFE.
REQ-040 pcEn=0 after 3 ticks for 10 sclk edges -> bitCount stays 3; resuming, word completes after 5 more ticks.
REQ-041 load and tick in the same cycle, then reset and load in the same cycle -> load wins the first case; the second gives reset values.

Source files
------------

// File: rtl/addr_sequencer.sv
// Address sequencer: counts sclk edges into words and steps memAddr through a loaded range.
// Latency: outputs registered, one clk after the qualifying edge; no backpressure, pcEn pauses counting.
module addr_sequencer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int BITS_PER_WORD = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclkPosEdge,
  input  logic                  pcEn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] loadStart,
  input  logic [ADDR_WIDTH-1:0] loadEnd,
  input  logic                  oneShot,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [CNT_WIDTH-1:0]  bitCount,
  output logic                  wordStrobe,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(BITS_PER_WORD - 1);

  logic [1:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] start_q,  start_d;
  logic [ADDR_WIDTH-1:0] end_q,    end_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
  logic                  strobe_q, strobe_d;
  logic                  tick;

  assign tick = (state_q == S_RUN) && pcEn && sclkPosEdge && !load;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (load) begin
      start_d = loadStart;
      end_d   = loadEnd;
      addr_d  = loadStart;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The sclk edge in the entry cycle is deliberately not counted.
          if (pcEn) state_d = S_RUN;
        end
        S_RUN: begin
          if (tick) begin
            if (cnt_q == LAST_BIT) begin
              cnt_d    = '0;
              strobe_d = 1'b1;
              if (addr_q != end_q) begin
                addr_d = addr_q + 1'b1;
              end else if (oneShot) begin
                state_d = S_DONE;
              end else begin
                addr_d = start_q;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      end_q    <= '1;
      addr_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      end_q    <= end_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign memAddr    = addr_q;
  assign bitCount   = cnt_q;
  assign wordStrobe = strobe_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule
